// File: rtl/cls_argmin_ctrl.sv
// Streaming argmin over CLS_NUM class distances, LANES per beat, with start/abort/result handshake.
// Optional res_dist output enabled by defining CLS_ARGMIN_DIST_OUT_EN.
`ifndef DIM
`define DIM 1024
`endif
`ifndef CLS_NUM
`define CLS_NUM 16
`endif
`ifndef CLS_DW
`define CLS_DW 4
`endif

module cls_argmin_ctrl #(
    parameter int LANES = 4,
    localparam int DW = $clog2(`DIM) + 1,
    localparam int IW = `CLS_DW
) (
    input  logic                dist_valid,
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                dist_ready,
    input  logic [LANES*DW-1:0] dist_data,
    output logic                res_valid,
    input  logic                res_ready,
`ifdef CLS_ARGMIN_DIST_OUT_EN
    output logic [DW-1:0]       res_dist,
`endif
    output logic [IW-1:0]       res_index
);

    localparam int BEATS = `CLS_NUM / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic [DW-1:0] best_dist_q, best_dist_d;
    logic [IW-1:0] best_idx_q, best_idx_d;

    logic [DW-1:0] lane_min;
    logic [LW-1:0] lane_idx;
    logic [IW-1:0] cand_idx;

    // Strict < keeps the lowest lane on ties.
    always_comb begin
        lane_min = dist_data[DW-1:0];
        lane_idx = '0;
        for (int unsigned i = 1; i < LANES; i++) begin
            if (dist_data[i*DW +: DW] < lane_min) begin
                lane_min = dist_data[i*DW +: DW];
                lane_idx = LW'(i);
            end
        end
        cand_idx = IW'(beat_cnt_q) * IW'(LANES) + IW'(lane_idx);
    end

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        best_dist_d = best_dist_q;
        best_idx_d  = best_idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_SCAN;
                    beat_cnt_d  = '0;
                    best_dist_d = '1;
                    best_idx_d  = '0;
                end
            end
            S_SCAN: begin
                // Abort takes priority over any beat presented in the same cycle.
                if (abort) begin
                    state_d = S_IDLE;
                end else if (dist_valid) begin
                    if (lane_min < best_dist_q) begin
                        best_dist_d = lane_min;
                        best_idx_d  = cand_idx;
                    end
                    if (beat_cnt_q == CW'(BEATS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            beat_cnt_q  <= '0;
            best_dist_q <= '0;
            best_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            best_dist_q <= best_dist_d;
            best_idx_q  <= best_idx_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign dist_ready = (state_q == S_SCAN);
    assign res_valid  = (state_q == S_DONE);
    assign res_index  = best_idx_q;
`ifdef CLS_ARGMIN_DIST_OUT_EN
    assign res_dist   = best_dist_q;
`endif

endmodule

// File: tb/tb_cls_argmin_ctrl.sv
// Directed testbench for cls_argmin_ctrl (DIM=1024, CLS_NUM=16, LANES=4).
// res_dist checks are active only when CLS_ARGMIN_DIST_OUT_EN is defined.
`ifndef DIM
`define DIM 1024
`endif
`ifndef CLS_NUM
`define CLS_NUM 16
`endif
`ifndef CLS_DW
`define CLS_DW 4
`endif

module tb_cls_argmin_ctrl;

    localparam int DW    = 11;
    localparam int LANES = 4;
    localparam int BEATS = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            busy;
    logic            dist_valid = 1'b0;
    logic            dist_ready;
    logic [LANES*DW-1:0] dist_data = '0;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [3:0]      res_index;
`ifdef CLS_ARGMIN_DIST_OUT_EN
    logic [DW-1:0]   res_dist;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cls[16];
    int scan_cycles;
    int seen_valid;

    always #5 clk = ~clk;

    cls_argmin_ctrl #(.LANES(LANES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .dist_valid(dist_valid),
        .dist_ready(dist_ready),
        .dist_data (dist_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
`ifdef CLS_ARGMIN_DIST_OUT_EN
        .res_dist  (res_dist),
`endif
        .res_index (res_index)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [LANES*DW-1:0] beat_data(input int b);
        logic [LANES*DW-1:0] d;
        d = '0;
        for (int k = 0; k < LANES; k++) d[k*DW +: DW] = DW'(cls[b*LANES + k]);
        return d;
    endfunction

    task automatic fill(input int v);
        for (int i = 0; i < 16; i++) cls[i] = v;
    endtask

    // All driving and sampling happens on the falling edge.
    task automatic run_query(input bit toggle, output int scans);
        int b, guard;
        bit phase;
        b = 0; guard = 0; phase = 1'b0; scans = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (res_valid !== 1'b1 && guard < 100) begin
            if (dist_ready === 1'b1) scans++;
            dist_valid = toggle ? phase : 1'b1;
            if (b < BEATS) dist_data = beat_data(b);
            if (dist_valid) b++;
            phase = ~phase;
            @(negedge clk);
            guard++;
        end
        dist_valid = 1'b0;
        if (guard >= 100) check("query_timeout", guard, 0);
    endtask

    task automatic finish_result();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("idle_after_hs", int'(busy), 0);
    endtask

    initial begin
        #3;
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(dist_ready), 0);
        check("rst_valid", int'(res_valid), 0);
        check("rst_index", int'(res_index), 0);
`ifdef CLS_ARGMIN_DIST_OUT_EN
        check("rst_dist", int'(res_dist), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // dist_valid in IDLE is ignored
        dist_valid = 1'b1;
        @(negedge clk);
        dist_valid = 1'b0;
        check("idle_valid_ign", int'(busy), 0);
        check("idle_ready", int'(dist_ready), 0);

        // REQ-030: single minimum, back-to-back beats, latency
        fill(100); cls[9] = 3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("scan_busy", int'(busy), 1);
        check("scan_ready", int'(dist_ready), 1);
        for (int b = 0; b < BEATS; b++) begin
            dist_valid = 1'b1;
            dist_data  = beat_data(b);
            check("no_early_valid", int'(res_valid), 0);
            @(negedge clk);
        end
        dist_valid = 1'b0;
        check("t1_latency", int'(res_valid), 1);
        check("t1_index", int'(res_index), 9);
        check("t1_done_ready", int'(dist_ready), 0);
`ifdef CLS_ARGMIN_DIST_OUT_EN
        check("t1_dist", int'(res_dist), 3);
`endif
        finish_result();

        // REQ-031: tie between class 5 and 12, toggling valid
        fill(50); cls[5] = 7; cls[12] = 7;
        run_query(1'b1, scan_cycles);
        check("t2_scan_cycles", scan_cycles, 8);
        check("t2_index", int'(res_index), 5);
`ifdef CLS_ARGMIN_DIST_OUT_EN
        check("t2_dist", int'(res_dist), 7);
`endif
        finish_result();

        // REQ-032: all-ones distances
        fill(2047);
        run_query(1'b0, scan_cycles);
        check("t3_index", int'(res_index), 0);
`ifdef CLS_ARGMIN_DIST_OUT_EN
        check("t3_dist", int'(res_dist), 2047);
`endif

        // REQ-033: hold in DONE, start ignored
        fill(900); cls[6] = 1;
        finish_result();
        run_query(1'b0, scan_cycles);
        for (int c = 0; c < 10; c++) begin
            start = (c == 3);
            @(negedge clk);
            check("t4_hold_valid", int'(res_valid), 1);
            check("t4_hold_index", int'(res_index), 6);
            check("t4_hold_busy", int'(busy), 1);
        end
        start = 1'b0;
        // start coincident with handshake must be ignored
        start = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; res_ready = 1'b0;
        check("t4_start_hs_ign", int'(busy), 0);
        @(negedge clk);
        check("t4_still_idle", int'(busy), 0);

        // REQ-034: abort on beat 2
        fill(300); cls[10] = 4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            dist_valid = 1'b1;
            dist_data  = beat_data(b);
            abort      = (b == 2);
            @(negedge clk);
        end
        dist_valid = 1'b0; abort = 1'b0;
        check("t5_abort_idle", int'(busy), 0);
        seen_valid = 0;
        for (int c = 0; c < 5; c++) begin
            if (res_valid === 1'b1) seen_valid++;
            @(negedge clk);
        end
        check("t5_no_result", seen_valid, 0);
        fill(60); cls[1] = 2;
        run_query(1'b0, scan_cycles);
        check("t5_new_index", int'(res_index), 1);
        finish_result();

        // REQ-022: abort coincident with final beat
        fill(80); cls[15] = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < BEATS; b++) begin
            dist_valid = 1'b1;
            dist_data  = beat_data(b);
            abort      = (b == BEATS - 1);
            @(negedge clk);
        end
        dist_valid = 1'b0; abort = 1'b0;
        check("t6_abort_last_valid", int'(res_valid), 0);
        check("t6_abort_last_busy", int'(busy), 0);

        // REQ-035: asynchronous reset mid-scan
        fill(200); cls[2] = 5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            dist_valid = 1'b1;
            dist_data  = beat_data(b);
            @(negedge clk);
        end
        dist_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t7_rst_busy", int'(busy), 0);
        check("t7_rst_ready", int'(dist_ready), 0);
        check("t7_rst_index", int'(res_index), 0);
`ifdef CLS_ARGMIN_DIST_OUT_EN
        check("t7_rst_dist", int'(res_dist), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t7_post_idle", int'(busy), 0);
        fill(500); cls[14] = 9; cls[3] = 9;
        cls[2] = 700;
        run_query(1'b0, scan_cycles);
        check("t7_fresh_index", int'(res_index), 3);
`ifdef CLS_ARGMIN_DIST_OUT_EN
        check("t7_fresh_dist", int'(res_dist), 9);
`endif
        finish_result();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
